// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, row type and loader state encoding for the systolic feeder path
package systolic_pkg;
    localparam int LANES  = 7;
    localparam int DATA_W = 8;
    localparam int SKEW_W = 3;
    localparam int ROW_W  = LANES * DATA_W;
    localparam int CNT_W  = $clog2(LANES + 1);
    typedef logic [ROW_W-1:0] row_t;
    typedef enum logic [1:0] {FILL, SKEW, LOAD, SHIFT} loader_state_t;
endpackage

// File: rtl/feeder_row_loader_if.sv
// feeder_row_loader_if: byte input stream plus the row/load/enable lane toward one data_feeder
interface feeder_row_loader_if;
    import systolic_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    row_t              feed_data;
    logic              feed_load;
    logic              feed_enable;
    modport master (
        input  in_valid, in_data,
        output in_ready, feed_data, feed_load, feed_enable
    );
    modport slave (
        output in_valid, in_data,
        input  in_ready, feed_data, feed_load, feed_enable
    );
endinterface

// File: rtl/feeder_row_packer.sv
// feeder_row_packer: packs accepted bytes MSB-first into one row and flags when the row is full
module feeder_row_packer
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_fill_en,
    input  logic              i_clear,
    output logic              o_ready,
    output row_t              o_pack,
    output logic              o_complete
);
    logic [CNT_W-1:0] r_count;
    row_t             r_pack;
    logic             w_accept;
    assign o_ready    = i_fill_en && (r_count < CNT_W'(LANES));
    assign w_accept   = i_valid && o_ready;
    assign o_complete = r_count == CNT_W'(LANES);
    assign o_pack     = r_pack;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pack  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_pack  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_pack[ROW_W-1-int'(r_count)*DATA_W -: DATA_W] <= i_data;
            r_count <= r_count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/feeder_row_loader.sv
// feeder_row_loader: packs byte rows and drives one data_feeder lane with skewed load/shift sequencing.
// Define FEEDER_ROW_LOADER_PREFETCH_EN to let the next row fill while the current one is skewed/loaded/shifted.
module feeder_row_loader
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SKEW_W-1:0] skew,
    output logic              busy,
    output logic              row_done,
    feeder_row_loader_if.master bus
);
    loader_state_t    r_state;
    loader_state_t    w_next;
    loader_state_t    w_go;
    logic [SKEW_W-1:0] r_skew_cnt;
    logic [CNT_W-1:0]  r_shift_cnt;
    logic              w_fill_en;
    logic              w_complete;
    logic              w_shift_last;
    row_t              w_pack;
    row_t              r_feed_data;
    logic              r_feed_load;
    logic              r_feed_enable;
`ifdef FEEDER_ROW_LOADER_PREFETCH_EN
    assign w_fill_en = 1'b1;
`else
    assign w_fill_en = r_state == FILL;
`endif
    // the pack is handed over and cleared on the same edge that enters LOAD
    feeder_row_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (bus.in_valid),
        .i_data     (bus.in_data),
        .i_fill_en  (w_fill_en),
        .i_clear    (w_next == LOAD),
        .o_ready    (bus.in_ready),
        .o_pack     (w_pack),
        .o_complete (w_complete)
    );
    always_comb begin
        w_shift_last = r_shift_cnt == CNT_W'(LANES - 1);
        w_go         = w_complete ? (skew != '0 ? SKEW : LOAD) : FILL;
        w_next       = r_state == FILL  ? w_go :
                       r_state == SKEW  ? (r_skew_cnt == '0 ? LOAD : SKEW) :
                       r_state == LOAD  ? SHIFT :
                       w_shift_last     ? w_go : SHIFT;
        busy         = r_state != FILL;
        row_done     = r_state == SHIFT && w_shift_last;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= FILL;
        else          r_state <= w_next;
    end
    // outside SKEW the counter tracks skew-1, so it freezes the value present at row completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_skew_cnt    <= '0;
            r_shift_cnt   <= '0;
            r_feed_data   <= '0;
            r_feed_load   <= 1'b0;
            r_feed_enable <= 1'b0;
        end else begin
            r_skew_cnt    <= r_state == SKEW ? r_skew_cnt - SKEW_W'(1) : skew - SKEW_W'(1);
            r_shift_cnt   <= r_state == SHIFT ? r_shift_cnt + CNT_W'(1) : '0;
            r_feed_load   <= w_next == LOAD;
            r_feed_enable <= w_next == SHIFT;
            if (w_next == LOAD) r_feed_data <= w_pack;
        end
    end
    assign bus.feed_data   = r_feed_data;
    assign bus.feed_load   = r_feed_load;
    assign bus.feed_enable = r_feed_enable;
endmodule
